// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: bus-mapped UART transmitter with TX FIFO,
// runtime baud divisor, optional parity and 1/2 stop bits.
// Ports: clk, rst_n (async, low); wr_en/addr/wdata bus write;
// rd_data register read (comb on addr); txd serial out (idle 1);
// busy = frame active or FIFO non-empty; irq = !busy.
module uart_tx_mmio #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 5208,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rd_data,
  output logic        txd,
  output logic        busy,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t state, state_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_n;
  logic overflow;

  logic [15:0] div_reg;
  logic [15:0] div_act, div_act_n;
  logic [15:0] timer, timer_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic par, par_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic stop_cnt, stop_cnt_n;
  logic txd_n, busy_n, tick;

  logic full, empty;
  logic push_req, push, pop;
  logic [DATA_BITS-1:0] head;
  logic unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push_req = wr_en && (addr == 2'd0);
  assign push     = push_req && !full;
  assign head     = mem[rptr];
  assign irq      = ~busy;

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    div_act_n  = div_act;
    shreg_n    = shreg;
    par_n      = par;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    txd_n      = txd;
    pop        = 1'b0;
    tick       = (timer == '0);

    // bit timer reloads at every bit boundary
    if (state != IDLE) begin
      timer_n = tick ? div_act - 16'd1 : timer - 16'd1;
    end

    unique case (state)
      IDLE: begin
        if (!empty) pop = 1'b1;
      end
      START: begin
        if (tick) begin
          state_n   = DATA;
          txd_n     = shreg[0];
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              txd_n   = par;
            end else begin
              state_n    = STOP;
              txd_n      = 1'b1;
              stop_cnt_n = 1'b0;
            end
          end else begin
            shreg_n   = shreg >> 1;
            txd_n     = shreg[1];
            bit_cnt_n = bit_cnt + 4'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_n    = STOP;
          txd_n      = 1'b1;
          stop_cnt_n = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt == LAST_STOP) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              state_n = IDLE;
              txd_n   = 1'b1;
            end
          end else begin
            stop_cnt_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // a pop starts a frame: divisor is latched here only,
    // so mid-frame DIV writes wait for the next start bit
    if (pop) begin
      state_n   = START;
      txd_n     = 1'b0;
      shreg_n   = head;
      par_n     = (^head) ^ (PARITY_ODD != 0);
      div_act_n = div_reg;
      timer_n   = div_reg - 16'd1;
    end

    count_n = count;
    if (push && !pop) count_n = count + CW'(1);
    if (!push && pop) count_n = count - CW'(1);

    busy_n = (state_n != IDLE) || (count_n != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      div_act  <= 16'(DIV_RESET);
      div_reg  <= 16'(DIV_RESET);
      shreg    <= '0;
      par      <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      div_act  <= div_act_n;
      shreg    <= shreg_n;
      par      <= par_n;
      bit_cnt  <= bit_cnt_n;
      stop_cnt <= stop_cnt_n;
      txd      <= txd_n;
      busy     <= busy_n;
      count    <= count_n;
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      // a push into a full FIFO is dropped even if a pop
      // frees a slot on the same edge
      if (push_req && full) begin
        overflow <= 1'b1;
      end else if (wr_en && addr == 2'd1 && wdata[3]) begin
        overflow <= 1'b0;
      end
      if (wr_en && addr == 2'd2) begin
        div_reg <= (wdata[15:0] == '0) ? 16'd1 : wdata[15:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata[DATA_BITS-1:0];
  end

  always_comb begin
    rd_data = '0;
    unique case (addr)
      2'd1: begin
        rd_data[0]       = full;
        rd_data[1]       = empty;
        rd_data[2]       = busy;
        rd_data[3]       = overflow;
        rd_data[8 +: CW] = count;
      end
      2'd2: rd_data[15:0] = div_reg;
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized bench for uart_tx_mmio against a
// frame/FIFO reference model; three parity/stop configurations.
module tb_uart_tx_mmio;

  localparam int D  = 16;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_en = 1'b0;
  logic [1:0] addr = 2'd1;
  logic [31:0] wdata = '0;
  logic [31:0] rd0, rd1, rd2;
  logic txd0, txd1, txd2;
  logic busy0, busy1, busy2;
  logic irq0, irq1, irq2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int burst_base = 0;
  logic [7:0] left_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_mmio dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rd_data(rd0), .txd(txd0),
    .busy(busy0), .irq(irq0)
  );

  uart_tx_mmio #(.PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
  dut_pe (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rd_data(rd1), .txd(txd1),
    .busy(busy1), .irq(irq1)
  );

  uart_tx_mmio #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
  dut_po (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr(addr),
    .wdata(wdata), .rd_data(rd2), .txd(txd2),
    .busy(busy2), .irq(irq2)
  );

  function automatic logic sel_txd(input int u);
    if (u == 0) return txd0;
    if (u == 1) return txd1;
    return txd2;
  endfunction

  function automatic logic sel_busy(input int u);
    if (u == 0) return busy0;
    if (u == 1) return busy1;
    return busy2;
  endfunction

  function automatic logic sel_irq(input int u);
    if (u == 0) return irq0;
    if (u == 1) return irq1;
    return irq2;
  endfunction

  function automatic logic [31:0] sel_rd(input int u);
    if (u == 0) return rd0;
    if (u == 1) return rd1;
    return rd2;
  endfunction

  // bits per frame: start + data + parity + stop(s)
  function automatic int frame_len_bits(input int u);
    return 1 + DB + ((u > 0) ? 1 : 0) + ((u > 0) ? 2 : 1);
  endfunction

  function automatic logic frame_bit(input logic [7:0] ch,
                                     input int u, input int i);
    if (i == 0) return 1'b0;
    if (i <= DB) return ch[i-1];
    if (u > 0 && i == DB + 1) return (^ch) ^ (u == 2);
    return 1'b1;
  endfunction

  task automatic do_reset();
    wr_en = 1'b0;
    addr  = 2'd1;
    wdata = '0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk);
    #1 wr_en = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 wr_en = 1'b0; addr = 2'd1;
  endtask

  task automatic reg_read(input int u, input logic [1:0] a,
                          output logic [31:0] d);
    @(posedge clk);
    #1 wr_en = 1'b0; addr = a;
    @(negedge clk);
    d = sel_rd(u);
  endtask

  // Pushes chs on consecutive edges 1..n (FSM idle, FIFO empty
  // before), samples nsamp cycles from edge 0 and compares with
  // an edge-level model of FIFO occupancy and frame timing.
  task automatic run_burst(input int u, input logic [7:0] chs[$],
                           input int div, input int nsamp);
    logic [7:0] q[$];
    logic [7:0] cur;
    int n, fl, fs, fe, pre, b0;
    bit ovf;
    logic etxd[$], ebusy[$], stxd[$], sbusy[$], sirq[$];
    logic [31:0] estat[$], srd[$];
    cur = 8'h00;
    n = chs.size();
    fl = div * frame_len_bits(u);
    fs = 0; fe = 0; ovf = 1'b0; b0 = 0;
    for (int e = 0; e < nsamp; e++) begin
      logic [31:0] st;
      pre = q.size();
      if (pre > 0 && e >= fe) begin
        cur = q.pop_front();
        fs = e;
        fe = e + fl;
      end
      if (e >= 1 && e <= n) begin
        if (pre == D) ovf = 1'b1;
        else q.push_back(chs[e-1]);
      end
      etxd.push_back((e < fe) ? frame_bit(cur, u, (e - fs) / div)
                              : 1'b1);
      ebusy.push_back((q.size() > 0) || (e < fe));
      st = '0;
      st[0] = (q.size() == D);
      st[1] = (q.size() == 0);
      st[2] = (q.size() > 0) || (e < fe);
      st[3] = ovf;
      st[16:8] = 9'(q.size());
      estat.push_back((e < n) ? 32'h0 : st);
    end
    left_q = q;
    fork
      begin
        for (int k = 0; k < n; k++) begin
          @(posedge clk);
          #1 wr_en = 1'b1; addr = 2'd0;
          wdata = $urandom();
          wdata[7:0] = chs[k];
        end
        @(posedge clk);
        #1 wr_en = 1'b0; addr = 2'd1;
      end
      begin
        @(posedge clk);
        for (int e = 0; e < nsamp; e++) begin
          @(negedge clk);
          if (e == 0) b0 = cyc;
          stxd.push_back(sel_txd(u));
          sbusy.push_back(sel_busy(u));
          sirq.push_back(sel_irq(u));
          srd.push_back(sel_rd(u));
        end
      end
    join
    burst_base = b0;
    for (int e = 0; e < nsamp; e++) begin
      checks++;
      if (stxd[e] !== etxd[e]) begin
        errors++;
        $display("FAIL burst_txd u%0d e=%0d: got %b want %b",
                 u, e, stxd[e], etxd[e]);
      end
      checks++;
      if (sbusy[e] !== ebusy[e]) begin
        errors++;
        $display("FAIL burst_busy u%0d e=%0d: got %b want %b",
                 u, e, sbusy[e], ebusy[e]);
      end
      checks++;
      if (sirq[e] !== !ebusy[e]) begin
        errors++;
        $display("FAIL burst_irq u%0d e=%0d: got %b want %b",
                 u, e, sirq[e], !ebusy[e]);
      end
      checks++;
      if (srd[e] !== estat[e]) begin
        errors++;
        $display("FAIL burst_rd u%0d e=%0d: got %h want %h",
                 u, e, srd[e], estat[e]);
      end
    end
  endtask

  // Checks contiguous frames starting at absolute edge start,
  // preceded by a high line and followed by idle with irq high.
  task automatic check_stream(input int u, input int start,
                              input int div, input logic [7:0] chs[$]);
    int nb;
    logic want;
    nb = frame_len_bits(u);
    @(negedge clk);
    checks++;
    if (cyc > start - 1) begin
      errors++;
      $display("FAIL stream_late u%0d: at edge %0d want <= %0d",
               u, cyc, start - 1);
      return;
    end
    while (cyc < start - 1) @(negedge clk);
    checks++;
    if (sel_txd(u) !== 1'b1) begin
      errors++;
      $display("FAIL stream_pre u%0d: got %b want 1", u, sel_txd(u));
    end
    foreach (chs[f]) begin
      for (int i = 0; i < nb * div; i++) begin
        @(negedge clk);
        want = frame_bit(chs[f], u, i / div);
        checks++;
        if (sel_txd(u) !== want) begin
          errors++;
          $display("FAIL stream_txd u%0d f=%0d c=%0d: got %b want %b",
                   u, f, i, sel_txd(u), want);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (sel_txd(u) !== 1'b1 || sel_irq(u) !== 1'b1) begin
      errors++;
      $display("FAIL stream_end u%0d: txd %b irq %b want 1 1",
               u, sel_txd(u), sel_irq(u));
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (sel_txd(u) !== 1'b1 || sel_busy(u) !== 1'b0 ||
          sel_irq(u) !== 1'b1) begin
        errors++;
        $display("FAIL reset_out u%0d: txd %b busy %b irq %b want 1 0 1",
                 u, sel_txd(u), sel_busy(u), sel_irq(u));
      end
    end
    reg_read(0, 2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL reset_status: got %h want 00000002", d);
    end
    reg_read(1, 2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL reset_status_pe: got %h want 00000002", d);
    end
    reg_read(0, 2'd2, d);
    checks++;
    if (d !== 32'd5208) begin
      errors++;
      $display("FAIL reset_div: got %0d want 5208", d);
    end
    reg_read(0, 2'd0, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL data_read: got %h want 0", d);
    end
    reg_write(2'd3, $urandom());
    reg_read(0, 2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reserved_read: got %h want 0", d);
    end
    reg_read(0, 2'd2, d);
    checks++;
    if (d !== 32'd5208) begin
      errors++;
      $display("FAIL reserved_write_div: got %0d want 5208", d);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] cq[$];
    int dv;
    do_reset();
    reg_write(2'd2, 32'd4);
    cq.delete();
    cq.push_back(8'h55);
    run_burst(0, cq, 4, 46);
    for (int r = 0; r < 3; r++) begin
      dv = $urandom_range(1, 5);
      do_reset();
      reg_write(2'd2, 32'(dv));
      cq.delete();
      cq.push_back(8'($urandom()));
      run_burst(0, cq, dv, 2 + 10 * dv + 4);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cq[$];
    int dv;
    do_reset();
    reg_write(2'd2, 32'd2);
    cq.delete();
    cq.push_back(8'h41);
    cq.push_back(8'h42);
    cq.push_back(8'h43);
    run_burst(0, cq, 2, 3 + 2 + 60 + 3);
    dv = $urandom_range(1, 3);
    do_reset();
    reg_write(2'd2, 32'(dv));
    cq.delete();
    for (int k = 0; k < 4; k++) cq.push_back(8'($urandom()));
    run_burst(0, cq, dv, 4 + 2 + 40 * dv + 3);
  endtask

  task automatic test_overflow();
    logic [7:0] cq[$];
    logic [31:0] d;
    int base;
    do_reset();
    reg_write(2'd2, 32'd1000);
    cq.delete();
    for (int k = 0; k < D + 2; k++) cq.push_back(8'($urandom()));
    run_burst(0, cq, 1000, D + 2 + 6);
    base = burst_base;
    reg_write(2'd1, 32'h8);
    reg_read(0, 2'd1, d);
    checks++;
    if (d !== 32'h0000_1005) begin
      errors++;
      $display("FAIL ovf_clear: got %h want 00001005", d);
    end
    reg_write(2'd2, 32'd1);
    check_stream(0, base + 2 + 10000, 1, left_q);
  endtask

  task automatic test_parity();
    logic [7:0] cq[$];
    for (int u = 1; u < 3; u++) begin
      do_reset();
      reg_write(2'd2, 32'd3);
      cq.delete();
      cq.push_back(8'h07);
      run_burst(u, cq, 3, 2 + 36 + 4);
      do_reset();
      reg_write(2'd2, 32'd2);
      cq.delete();
      cq.push_back(8'($urandom()));
      cq.push_back(8'($urandom()));
      run_burst(u, cq, 2, 2 + 2 + 48 + 4);
    end
  endtask

  task automatic test_div_change();
    logic [7:0] cq[$];
    logic [31:0] d;
    logic [7:0] b;
    int base;
    do_reset();
    reg_write(2'd2, 32'd4);
    cq.delete();
    cq.push_back(8'($urandom()));
    run_burst(0, cq, 4, 5);
    base = burst_base;
    b = 8'($urandom());
    reg_write(2'd2, 32'd8);
    reg_write(2'd0, {24'h0, b});
    cq.delete();
    cq.push_back(b);
    check_stream(0, base + 42, 8, cq);
    reg_write(2'd2, 32'h0);
    reg_read(0, 2'd2, d);
    checks++;
    if (d !== 32'd1) begin
      errors++;
      $display("FAIL div_zero: got %0d want 1", d);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    reg_write(2'd2, 32'd4);
    reg_write(2'd0, 32'h0);
    reg_write(2'd0, 32'h0);
    repeat (6) @(posedge clk);
    #3;
    checks++;
    if (txd0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: txd %b busy %b want 0 1", txd0, busy0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (txd0 !== 1'b1 || txd1 !== 1'b1 || txd2 !== 1'b1) begin
      errors++;
      $display("FAIL async_txd: got %b%b%b want 111", txd0, txd1, txd2);
    end
    checks++;
    if (busy0 !== 1'b0 || irq0 !== 1'b1) begin
      errors++;
      $display("FAIL async_busy: busy %b irq %b want 0 1", busy0, irq0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    reg_read(0, 2'd1, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL post_reset_status: got %h want 00000002", d);
    end
    reg_read(0, 2'd2, d);
    checks++;
    if (d !== 32'd5208) begin
      errors++;
      $display("FAIL post_reset_div: got %0d want 5208", d);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (txd0 !== 1'b1 || irq0 !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: txd %b irq %b want 1 1",
               txd0, irq0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_div_change();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
